// File: rtl/lcd_page_scheduler_if.sv
// Source-fetch and text-buffer write bus between the page scheduler,
// the page sources and the LCD driver's 32-entry text buffer.
interface lcd_page_scheduler_if #(
    parameter int NUM_CHARS = 32,
    parameter int DATA_BITS = 8
);
    localparam int ADDR_BITS = $clog2(NUM_CHARS);

    logic [1:0]           src_sel;
    logic [ADDR_BITS-1:0] src_addr;
    logic [DATA_BITS-1:0] src_char;
    logic                 buf_we;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [DATA_BITS-1:0] buf_data;

    modport master (
        output src_sel,
        output src_addr,
        input  src_char,
        output buf_we,
        output buf_addr,
        output buf_data
    );

    modport slave (
        input  src_sel,
        input  src_addr,
        output src_char,
        input  buf_we,
        input  buf_addr,
        input  buf_data
    );
endinterface

// File: rtl/lcd_page_scheduler.sv
// Chooses which 32-char page the LCD shows and copies it into the driver's
// text buffer after every refresh; rotates pages 0/1 and lets alerts pre-empt.
module lcd_page_scheduler #(
    parameter int NUM_CHARS    = 32,
    parameter int DATA_BITS    = 8,
    parameter int DWELL_FRAMES = 4,
    parameter int ALERT_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lcd_frame_done,
    input  logic                  status_en,
    input  logic                  alert_req,
    output logic                  alert_ack,
    output logic [1:0]            active_page,
    output logic                  busy,
    lcd_page_scheduler_if.master  bus
);
    localparam int ADDR_BITS = $clog2(NUM_CHARS);
    localparam int DWELL_W   = $clog2(DWELL_FRAMES) + 1;
    localparam int ALERT_W   = $clog2(ALERT_FRAMES) + 1;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_CHARS - 1);
    localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [ALERT_W-1:0]   ALERT_LOAD = ALERT_W'(ALERT_FRAMES - 1);
    localparam logic [1:0]           PAGE_CLOCK  = 2'd0;
    localparam logic [1:0]           PAGE_STATUS = 2'd1;
    localparam logic [1:0]           PAGE_ALERT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        COPY,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [1:0]         page_next;
    logic               sel_alert;
    logic               sel_return;
    logic [1:0]         rot_page;
    logic               toggle_pend;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [ALERT_W-1:0] alert_cnt;
    logic               alert_pend;
    logic               alert_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        page_next  = active_page;
        sel_alert  = 1'b0;
        sel_return = 1'b0;
        alert_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (lcd_frame_done) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                state_next = COPY;
                if (alert_pend) begin
                    page_next = PAGE_ALERT;
                    sel_alert = 1'b1;
                end else if (active_page == PAGE_ALERT) begin
                    if (alert_expired) begin
                        alert_ack  = 1'b1;
                        sel_return = 1'b1;
                        page_next  = status_en ? rot_page : PAGE_CLOCK;
                    end
                end else if (!status_en) begin
                    page_next = PAGE_CLOCK;
                end else if (toggle_pend) begin
                    page_next = (rot_page == PAGE_CLOCK) ? PAGE_STATUS : PAGE_CLOCK;
                end else begin
                    page_next = rot_page;
                end
            end
            COPY: begin
                if (bus.src_addr == LAST_ADDR) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Copy datapath: src_addr walks the page while the previous char is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.buf_we   <= 1'b0;
            bus.buf_addr <= '0;
            bus.buf_data <= DATA_BITS'(8'h20);
            bus.src_sel  <= PAGE_CLOCK;
            bus.src_addr <= '0;
            active_page  <= PAGE_CLOCK;
            rot_page     <= PAGE_CLOCK;
        end else begin
            bus.buf_we <= (state == COPY);
            if (state == COPY) begin
                bus.buf_addr <= bus.src_addr;
                bus.buf_data <= bus.src_char;
            end
            if (state == SELECT) begin
                bus.src_sel  <= page_next;
                active_page  <= page_next;
                bus.src_addr <= '0;
                if (page_next != PAGE_ALERT) begin
                    rot_page <= page_next;
                end
            end else if (state == COPY && bus.src_addr != LAST_ADDR) begin
                bus.src_addr <= bus.src_addr + 1'b1;
            end
        end
    end

    // Frame counters run in every state, so refreshes during a copy still count.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt     <= '0;
            toggle_pend   <= 1'b0;
            alert_cnt     <= '0;
            alert_pend    <= 1'b0;
            alert_expired <= 1'b0;
        end else begin
            if (state == SELECT && sel_alert) begin
                alert_pend <= 1'b0;
            end
            if (alert_req) begin
                alert_pend <= 1'b1;
            end

            // The window closes at the first refresh that finds the count already at 0.
            if (state == SELECT && sel_alert) begin
                alert_cnt     <= ALERT_LOAD;
                alert_expired <= 1'b0;
            end else if (state == SELECT && sel_return) begin
                alert_expired <= 1'b0;
            end else if (lcd_frame_done && active_page == PAGE_ALERT) begin
                if (alert_cnt == '0) begin
                    alert_expired <= 1'b1;
                end else begin
                    alert_cnt <= alert_cnt - ALERT_W'(1);
                end
            end

            if (state == SELECT) begin
                toggle_pend <= 1'b0;
            end
            if (state == SELECT && sel_return) begin
                dwell_cnt <= '0;
            end else if (lcd_frame_done && active_page != PAGE_ALERT) begin
                if (dwell_cnt >= DWELL_LAST) begin
                    dwell_cnt   <= '0;
                    toggle_pend <= 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_page_scheduler.sv
// Directed bench for lcd_page_scheduler: expected copies are queued by the
// stimulus and checked write-by-write by an independent buffer monitor.
module tb_lcd_page_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_frame_done = 1'b0;
    logic       status_en = 1'b0;
    logic       alert_req = 1'b0;
    logic       alert_ack;
    logic [1:0] active_page;
    logic       busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int page;
        bit ack;
    } exp_t;

    exp_t exp_q[$];
    int   mon_idx = 0;
    bit   seen_ack = 1'b0;

    lcd_page_scheduler_if #(.NUM_CHARS(32), .DATA_BITS(8)) bus ();

    // Page sources: a distinct printable char per (page, index).
    assign bus.src_char = 8'h20 + {1'b0, bus.src_sel, bus.src_addr};

    lcd_page_scheduler #(
        .NUM_CHARS(32),
        .DATA_BITS(8),
        .DWELL_FRAMES(4),
        .ALERT_FRAMES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lcd_frame_done(lcd_frame_done),
        .status_en(status_en),
        .alert_req(alert_req),
        .alert_ack(alert_ack),
        .active_page(active_page),
        .busy(busy),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_idx  = 0;
            seen_ack = 1'b0;
        end else begin
            if (alert_ack) begin
                seen_ack = 1'b1;
            end
            if (bus.buf_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("buf_addr", bus.buf_addr, mon_idx);
                    check("buf_data", bus.buf_data, 32 + exp_q[0].page * 32 + mon_idx);
                    mon_idx++;
                    if (mon_idx == 32) begin
                        check("alert_ack_seen", seen_ack, exp_q[0].ack);
                        check("active_page", active_page, exp_q[0].page);
                        void'(exp_q.pop_front());
                        mon_idx  = 0;
                        seen_ack = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_alert();
        alert_req = 1'b1;
        @(posedge clk);
        #1;
        alert_req = 1'b0;
    endtask

    task automatic pulse_frame();
        lcd_frame_done = 1'b1;
        @(posedge clk);
        #1;
        lcd_frame_done = 1'b0;
    endtask

    // Counts remaining busy cycles; a stuck copy ends at the bound.
    task automatic wait_copy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
    endtask

    task automatic frame(input int pg, input bit ack);
        int n;
        exp_q.push_back('{pg, ack});
        pulse_frame();
        wait_copy(n);
        check("busy_cycles", n, 34);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state and a single clock-page copy.
        do_reset();
        @(negedge clk);
        check("rst_buf_we", bus.buf_we, 0);
        check("rst_buf_addr", bus.buf_addr, 0);
        check("rst_buf_data", bus.buf_data, 32);
        check("rst_src_sel", bus.src_sel, 0);
        check("rst_src_addr", bus.src_addr, 0);
        check("rst_active_page", active_page, 0);
        check("rst_alert_ack", alert_ack, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        status_en = 1'b0;
        frame(0, 0);

        // Rotation with status page enabled.
        do_reset();
        status_en = 1'b1;
        frame(0, 0); frame(0, 0); frame(0, 0); frame(1, 0);
        frame(1, 0); frame(1, 0); frame(1, 0); frame(0, 0);

        // Alert window: 8 frames of page 2, ack on the 9th, then rotation resumes.
        pulse_alert();
        for (int i = 0; i < 8; i++) frame(2, 0);
        frame(0, 1);
        frame(0, 0);

        // Refresh during a copy: ignored for restart but counted for dwell.
        do_reset();
        status_en = 1'b1;
        exp_q.push_back('{0, 0});
        pulse_frame();
        repeat (6) @(posedge clk);
        #1;
        pulse_frame();
        wait_copy(n);
        check("busy_after_midpulse", n, 27);
        repeat (8) @(posedge clk);
        #1;
        frame(0, 0);
        frame(1, 0);

        // Reset in the middle of an alert-page copy.
        pulse_alert();
        exp_q.push_back('{2, 0});
        pulse_frame();
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_buf_we", bus.buf_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_active_page", active_page, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        frame(0, 0);

        // Drop status_en while page 1 is up, then re-armed alert.
        do_reset();
        status_en = 1'b1;
        frame(0, 0); frame(0, 0); frame(0, 0); frame(1, 0);
        status_en = 1'b0;
        frame(0, 0);
        pulse_alert();
        for (int i = 0; i < 5; i++) frame(2, 0);
        pulse_alert();
        for (int i = 0; i < 8; i++) frame(2, 0);
        frame(0, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
